// File: rtl/alsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alsu_pkg
//  Description : Shared opcode constants, FSM state type and the
//                invalid-operation rule for the ALSU.
//  Revision    : 1.0 - initial release
// ============================================================================
package alsu_pkg;

  localparam logic [2:0] OP_AND   = 3'd0;
  localparam logic [2:0] OP_XOR   = 3'd1;
  localparam logic [2:0] OP_ADD   = 3'd2;
  localparam logic [2:0] OP_MUL   = 3'd3;
  localparam logic [2:0] OP_SHIFT = 3'd4;
  localparam logic [2:0] OP_ROT   = 3'd5;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alsu_state_e;

  // Reduction flags only make sense for AND/XOR; opcodes 6 and 7 are unused.
  function automatic logic is_invalid(input logic [2:0] opc,
                                      input logic       red_a,
                                      input logic       red_b);
    return ((red_a | red_b) && (opc[2:1] != 2'b00)) ||
           (opc == 3'd6) || (opc == 3'd7);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alsu_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : alsu_gen_if
//  Description : Request/response bundle of the ALSU. The master drives the
//                operation request, the slave (the ALSU) drives the result.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alsu_gen_if #(
  parameter int WIDTH = 8,
  parameter int LED_W = 16
) ();

  logic                 in_valid;
  logic                 in_ready;
  logic                 cin;
  logic                 red_op_A;
  logic                 red_op_B;
  logic                 bypass_A;
  logic                 bypass_B;
  logic                 direction;
  logic                 serial_in;
  logic [2:0]           opcode;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic [2*WIDTH-1:0]   out;
  logic                 out_valid;
  logic                 err;
  logic [LED_W-1:0]     leds;

  modport master (
    output in_valid, cin, red_op_A, red_op_B, bypass_A, bypass_B,
           direction, serial_in, opcode, A, B,
    input  in_ready, out, out_valid, err, leds
  );

  modport slave (
    input  in_valid, cin, red_op_A, red_op_B, bypass_A, bypass_B,
           direction, serial_in, opcode, A, B,
    output in_ready, out, out_valid, err, leds
  );

endinterface
`default_nettype wire

// File: rtl/alsu_seq_mult.sv
`default_nettype none
// ============================================================================
//  Module      : alsu_seq_mult
//  Description : Unsigned shift-add multiplier, one partial product per
//                cycle. Operands are latched on start; done pulses for one
//                cycle once the product is final. last flags the final
//                iteration so the controller can release its busy state.
//  Revision    : 1.0 - initial release
// ============================================================================
module alsu_seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 last,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q,   acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               done_q,  done_d;

  // Load operands on start, then consume one multiplier bit per cycle.
  always_comb begin
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    if (start) begin
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = CNT_W'(WIDTH);
    end else if (cnt_q != '0) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - 1'b1;
      done_d   = (cnt_q == CNT_W'(1));
    end
  end

  // Multiplier state registers; reset aborts any multiply in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
    end
  end

  assign last    = (cnt_q == CNT_W'(1));
  assign done    = done_q;
  assign product = acc_q;

endmodule
`default_nettype wire

// File: rtl/alsu_gen.sv
`default_nettype none
// ============================================================================
//  Module      : alsu_gen
//  Description : Arithmetic/logic/shift unit with ready/valid request,
//                sequential multiplier, error flag and blinking error LEDs.
//                Requests are captured on acceptance; single-cycle results
//                are written one cycle later, multiplies WIDTH+1 cycles later.
//  Revision    : 1.0 - initial release
// ============================================================================
module alsu_gen
  import alsu_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter     INPUT_PRIORITY = "A",
  parameter     FULL_ADDER     = "ON",
  parameter int LED_W          = 16,
  parameter int BLINK_DIV      = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  alsu_gen_if.slave   bus
);

  localparam bit PRIO_A  = (INPUT_PRIORITY == "A");
  localparam bit FA_ON   = (FULL_ADDER == "ON");
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  typedef struct packed {
    logic [2:0]       opcode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             red_a;
    logic             red_b;
    logic             byp_a;
    logic             byp_b;
    logic             dir;
    logic             sin;
  } req_t;

  alsu_state_e         state_q, state_d;
  req_t                req_q, req_d;
  logic                pend_q, pend_d;
  logic [2*WIDTH-1:0]  out_q, out_d;
  logic                out_valid_q, out_valid_d;
  logic                err_q, err_d;
  logic [LED_W-1:0]    leds_q, leds_d;
  logic [BLINK_W-1:0]  blink_q, blink_d;

  logic                accept;
  logic                go_mul;
  logic                mult_last;
  logic                mult_done;
  logic [2*WIDTH-1:0]  mult_product;
  logic [2*WIDTH-1:0]  res;
  logic                res_err;

  alsu_seq_mult #(.WIDTH(WIDTH)) u_mult (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (go_mul),
    .a       (bus.A),
    .b       (bus.B),
    .last    (mult_last),
    .done    (mult_done),
    .product (mult_product)
  );

  // Request acceptance, FSM next state and capture of single-cycle requests.
  always_comb begin
    accept  = bus.in_valid && (state_q == ST_IDLE);
    go_mul  = accept && (bus.opcode == OP_MUL) &&
              !(bus.bypass_A || bus.bypass_B) &&
              !is_invalid(bus.opcode, bus.red_op_A, bus.red_op_B);
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (go_mul)    state_d = ST_MUL;
      ST_MUL:  if (mult_last) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
    pend_d = accept && !go_mul;
    req_d  = req_q;
    if (accept) begin
      req_d = '{opcode: bus.opcode, a: bus.A, b: bus.B, cin: bus.cin,
                red_a: bus.red_op_A, red_b: bus.red_op_B,
                byp_a: bus.bypass_A, byp_b: bus.bypass_B,
                dir: bus.direction, sin: bus.serial_in};
    end
  end

  // Result of a captured single-cycle request: bypass, then invalid, then opcode.
  always_comb begin
    res     = '0;
    res_err = 1'b0;
    if (req_q.byp_a && req_q.byp_b) begin
      res = {{WIDTH{1'b0}}, (PRIO_A ? req_q.a : req_q.b)};
    end else if (req_q.byp_a) begin
      res = {{WIDTH{1'b0}}, req_q.a};
    end else if (req_q.byp_b) begin
      res = {{WIDTH{1'b0}}, req_q.b};
    end else if (is_invalid(req_q.opcode, req_q.red_a, req_q.red_b)) begin
      res_err = 1'b1;
    end else begin
      case (req_q.opcode)
        OP_AND: begin
          if (req_q.red_a && req_q.red_b)
            res = {{(2*WIDTH-1){1'b0}}, (PRIO_A ? &req_q.a : &req_q.b)};
          else if (req_q.red_a)
            res = {{(2*WIDTH-1){1'b0}}, &req_q.a};
          else if (req_q.red_b)
            res = {{(2*WIDTH-1){1'b0}}, &req_q.b};
          else
            res = {{WIDTH{1'b0}}, req_q.a & req_q.b};
        end
        OP_XOR: begin
          if (req_q.red_a && req_q.red_b)
            res = {{(2*WIDTH-1){1'b0}}, (PRIO_A ? ^req_q.a : ^req_q.b)};
          else if (req_q.red_a)
            res = {{(2*WIDTH-1){1'b0}}, ^req_q.a};
          else if (req_q.red_b)
            res = {{(2*WIDTH-1){1'b0}}, ^req_q.b};
          else
            res = {{WIDTH{1'b0}}, req_q.a ^ req_q.b};
        end
        OP_ADD: begin
          res = {{WIDTH{1'b0}}, req_q.a} + {{WIDTH{1'b0}}, req_q.b} +
                {{(2*WIDTH-1){1'b0}}, (req_q.cin & FA_ON)};
        end
        OP_SHIFT: begin
          res = req_q.dir ? {out_q[2*WIDTH-2:0], req_q.sin}
                          : {req_q.sin, out_q[2*WIDTH-1:1]};
        end
        OP_ROT: begin
          res = req_q.dir ? {out_q[2*WIDTH-2:0], out_q[2*WIDTH-1]}
                          : {out_q[0], out_q[2*WIDTH-1:1]};
        end
        default: res = '0;
      endcase
    end
  end

  // Output register update and LED blink pattern while the error flag is set.
  always_comb begin
    out_d       = out_q;
    out_valid_d = 1'b0;
    err_d       = err_q;
    if (mult_done) begin
      out_d       = mult_product;
      out_valid_d = 1'b1;
      err_d       = 1'b0;
    end else if (pend_q) begin
      out_d       = res;
      out_valid_d = 1'b1;
      err_d       = res_err;
    end
    leds_d  = leds_q;
    blink_d = blink_q;
    if (!err_d || !err_q) begin
      // Cleared error, or error just rising: restart the blink phase dark.
      leds_d  = '0;
      blink_d = '0;
    end else if (blink_q == BLINK_W'(BLINK_DIV - 1)) begin
      leds_d  = ~leds_q;
      blink_d = '0;
    end else begin
      blink_d = blink_q + 1'b1;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      pend_q      <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      leds_q      <= '0;
      blink_q     <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      pend_q      <= pend_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      leds_q      <= leds_d;
      blink_q     <= blink_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.err       = err_q;
  assign bus.leds      = leds_q;

endmodule
`default_nettype wire

// File: tb/tb_alsu_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alsu_gen
//  Description : Self-checking bench for alsu_gen (WIDTH=4). Expected results
//                come from an arithmetic reference model and are queued at
//                issue time; a monitor pops them whenever out_valid is seen.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alsu_gen;

  localparam int W     = 4;
  localparam     PRIO  = "B";
  localparam     FA    = "ON";
  localparam int LED_W = 16;
  localparam int BD    = 4;

  typedef struct packed {
    logic [2*W-1:0] out;
    logic           err;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  exp_t mon_e;
  logic [63:0] model_out;

  alsu_gen_if #(.WIDTH(W), .LED_W(LED_W)) bus ();

  alsu_gen #(
    .WIDTH(W), .INPUT_PRIORITY(PRIO), .FULL_ADDER(FA),
    .LED_W(LED_W), .BLINK_DIV(BD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference model: result and error flag computed from the operation rules.
  function automatic exp_t model(input logic [63:0] prev, input int opc, input int a,
                                 input int b, input bit ci, input bit ra, input bit rb,
                                 input bit ba, input bit bb, input bit dir, input bit si);
    logic [63:0] mask, top, r;
    int   sel;
    exp_t e;
    mask = (64'd1 << (2*W)) - 1;
    top  = 64'd1 << (2*W-1);
    r    = 0;
    e.err = 1'b0;
    sel  = (ra && rb) ? ((PRIO == "A") ? a : b) : (ra ? a : b);
    if (ba || bb) begin
      r = (ba && bb) ? ((PRIO == "A") ? a : b) : (ba ? a : b);
    end else if (((ra || rb) && opc >= 2) || opc >= 6) begin
      r = 0;
      e.err = 1'b1;
    end else begin
      case (opc)
        0: r = (ra || rb) ? ((sel == (1 << W) - 1) ? 1 : 0) : (a & b);
        1: r = (ra || rb) ? ($countones(sel) % 2) : (a ^ b);
        2: r = a + b + ((FA == "ON") ? int'(ci) : 0);
        3: r = a * b;
        4: r = dir ? (((prev * 2) + si) & mask) : ((prev / 2) + (si ? top : 0));
        default: r = dir ? (((prev * 2) & mask) + (prev / top))
                         : ((prev / 2) + ((prev % 2 == 1) ? top : 0));
      endcase
    end
    e.out = r[2*W-1:0];
    return e;
  endfunction

  // Present one request, queue its expected response, hold until accepted.
  task automatic issue(input int opc, input int a, input int b, input bit ci,
                       input bit ra, input bit rb, input bit ba, input bit bb,
                       input bit dir, input bit si);
    int   guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    while (!bus.in_ready && guard < 100) begin
      guard++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      chk("ready_timeout", 64'(bus.in_ready), 64'd1);
      return;
    end
    bus.opcode = 3'(opc); bus.A = W'(a); bus.B = W'(b); bus.cin = ci;
    bus.red_op_A = ra; bus.red_op_B = rb; bus.bypass_A = ba; bus.bypass_B = bb;
    bus.direction = dir; bus.serial_in = si; bus.in_valid = 1'b1;
    e = model(model_out, opc, a, b, ci, ra, rb, ba, bb, dir, si);
    model_out = 64'(e.out);
    sb_q.push_back(e);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // Monitor: every out_valid must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out_valid out=%0h err=%b", bus.out, bus.err);
      end else begin
        mon_e = sb_q.pop_front();
        if (bus.out !== mon_e.out || bus.err !== mon_e.err) begin
          errors++;
          $display("FAIL result actual out=%0h err=%b required out=%0h err=%b",
                   bus.out, bus.err, mon_e.out, mon_e.err);
        end
      end
    end
  end

  task automatic settle2();
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    int first;
    int pulses;
    int guard;
    logic [LED_W-1:0] exp_leds;

    model_out = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.opcode = '0; bus.A = '0; bus.B = '0; bus.cin = 1'b0;
    bus.red_op_A = 1'b0; bus.red_op_B = 1'b0; bus.bypass_A = 1'b0; bus.bypass_B = 1'b0;
    bus.direction = 1'b0; bus.serial_in = 1'b0;
    #12;
    chk("rst_out", 64'(bus.out), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_err", 64'(bus.err), 64'd0);
    chk("rst_leds", 64'(bus.leds), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Add with carry-in, one-cycle latency.
    issue(2, 15, 15, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("add_valid_early", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    chk("add_valid", 64'(bus.out_valid), 64'd1);
    chk("add_out", 64'(bus.out), (FA == "ON") ? 64'h1F : 64'h1E);

    // Multiply with junk requests and changing operands during MUL.
    issue(3, 13, 11, 0, 0, 0, 0, 0, 0, 0);
    bus.in_valid = 1'b1; bus.opcode = 3'd6; bus.A = 4'd2; bus.B = 4'd7;
    first = -1;
    pulses = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n <= 4) chk("mul_ready_low", 64'(bus.in_ready), 64'd0);
      if (n == 4) bus.in_valid = 1'b0;
      if (n == 5) chk("mul_ready_back", 64'(bus.in_ready), 64'd1);
      if (bus.out_valid) begin
        pulses++;
        if (first < 0) begin
          first = n;
          chk("mul_out", 64'(bus.out), 64'h8F);
        end
      end
    end
    chk("mul_latency", 64'(first), 64'd6);
    chk("mul_pulses", 64'(pulses), 64'd1);

    // Invalid operation and LED blink pattern.
    issue(6, 5, 5, 0, 0, 0, 0, 0, 0, 0);
    for (int n = 1; n <= 3*BD + 2; n++) begin
      @(negedge clk);
      if (n == 2) chk("inv_out", 64'(bus.out), 64'd0);
      if (n >= 2) begin
        exp_leds = (((n - 2) / BD) % 2 == 1) ? {LED_W{1'b1}} : '0;
        chk("inv_err", 64'(bus.err), 64'd1);
        chk("inv_leds", 64'(bus.leds), 64'(exp_leds));
      end
    end
    issue(0, 5, 3, 0, 0, 0, 0, 0, 0, 0);
    settle2();
    chk("clr_err", 64'(bus.err), 64'd0);
    chk("clr_leds", 64'(bus.leds), 64'd0);

    // Shift and rotate starting from 8'h81.
    issue(0, 3, 0, 0, 0, 0, 1, 0, 0, 0);
    issue(4, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    settle2();
    chk("make_81", 64'(bus.out), 64'h81);
    issue(4, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    settle2();
    chk("shift_left", 64'(bus.out), 64'h02);
    issue(0, 3, 0, 0, 0, 0, 1, 0, 0, 0);
    issue(4, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    issue(5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    settle2();
    chk("rot_right", 64'(bus.out), 64'hC0);

    // Both bypass flags set.
    issue(2, 3, 9, 0, 0, 0, 1, 1, 0, 0);
    settle2();
    chk("bypass_both", 64'(bus.out), (PRIO == "A") ? 64'h03 : 64'h09);

    // Randomized operations checked by the monitor.
    for (int i = 0; i < 150; i++) begin
      issue(int'($urandom_range(0, 7)), int'($urandom_range(0, (1 << W) - 1)),
            int'($urandom_range(0, (1 << W) - 1)), 1'($urandom),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
            1'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    guard = 0;
    while (sb_q.size() != 0 && guard < 50) begin
      guard++;
      @(negedge clk);
    end
    chk("drain_random", 64'(sb_q.size()), 64'd0);

    // Reset in the middle of a multiply.
    issue(3, 7, 9, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out", 64'(bus.out), 64'd0);
    chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_err", 64'(bus.err), 64'd0);
    chk("mid_rst_leds", 64'(bus.leds), 64'd0);
    chk("mid_rst_ready", 64'(bus.in_ready), 64'd1);
    sb_q.delete();
    model_out = 0;
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (bus.out_valid) pulses++;
    end
    chk("no_valid_after_rst", 64'(pulses), 64'd0);
    chk("ready_after_rst", 64'(bus.in_ready), 64'd1);
    chk("final_queue", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alsu_gen.md
ALSU_GEN -- requirements
Module: alsu_gen

Interface
REQ-001 Parameter WIDTH, default 8, operand width (2..16).
REQ-002 Parameter INPUT_PRIORITY, default "A", selects operand when both bypass or both reduction flags are set ("A" or "B").
REQ-003 Parameter FULL_ADDER, default "ON", selects whether cin enters the add ("ON" or "OFF").
REQ-004 Parameter LED_W, default 16, LED vector width.
REQ-005 Parameter BLINK_DIV, default 4, cycles between LED toggles while in error (>=1).
REQ-006 One clock; reset is asynchronous and active-low.
REQ-007 Port clk, input, 1 bit, rising-edge clock.
REQ-008 Port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-009 Port in_valid, input, 1 bit, operation request.
REQ-010 Port in_ready, output, 1 bit, block can accept an operation.
REQ-011 Ports cin, red_op_A, red_op_B, bypass_A, bypass_B, direction and serial_in are inputs, 1 bit each, and carry control fields.
REQ-012 Port opcode, input, 3 bits, operation select.
REQ-013 Ports A and B, inputs, WIDTH bits each, operands.
REQ-014 Port out, output, 2*WIDTH bits, result register.
REQ-015 Port out_valid, output, 1 bit, one-cycle pulse when out is updated.
REQ-016 Port err, output, 1 bit, the last accepted operation was invalid.
REQ-017 Port leds, output, LED_W bits, error blink pattern.

Function
REQ-018 Accept: all inputs are captured on the rising edge where in_valid && in_ready; inputs are ignored otherwise.
REQ-019 Handshake: in_ready = 1 in IDLE and 0 in MUL.
REQ-020 FSM states:
- IDLE: an accepted opcode 3 that is not invalid or bypassed goes to MUL; every other accepted operation stays in IDLE.
- MUL: runs WIDTH iterations, then returns to IDLE.
REQ-021 Invalid operation:
- (red_op_A | red_op_B) with opcode[2:1] != 0, or opcode in {6, 7}.
- Bypass overrides invalid.
REQ-022 Priority: bypass both (INPUT_PRIORITY operand), then bypass_A, then bypass_B, then invalid, then opcode.
- Bypassed operand is zero-extended.
- An invalid operation loads out = 0.
REQ-023 opcode 0: bitwise A&B; with a reduction flag, &A or &B (INPUT_PRIORITY when both flags are set), zero-extended.
REQ-024 opcode 1: same as opcode 0 with XOR.
REQ-025 opcode 2: out = A + B + (FULL_ADDER=="ON" ? cin : 0), zero-extended and carry kept.
REQ-026 opcode 3: unsigned A*B by shift-add.
- One partial product per cycle in MUL.
- out and out_valid update WIDTH+1 cycles after acceptance.
REQ-027 opcode 4: shift the current out (2*WIDTH bits).
- direction=1: {out[2W-2:0], serial_in}.
- direction=0: {serial_in, out[2W-1:1]}.
REQ-028 opcode 5: rotate out; direction=1 rotates left, direction=0 rotates right.
REQ-029 Latency: every non-multiply operation updates out, with a one-cycle out_valid, on the cycle after acceptance.
REQ-030 out holds its value between operations; out_valid = 0 except on update cycles.
REQ-031 err:
- Set with the out update of an invalid operation.
- Cleared with the out update of any valid or bypassed operation.
REQ-032 LEDs:
- While err = 1, leds inverts every BLINK_DIV cycles, using a cycle counter reset when err rises.
- While err = 0, leds = 0.
REQ-033 The multiply result is computed from the captured operands; A and B may change during MUL without effect.

Reset
REQ-034 rst_n = 0 immediately forces, regardless of clk:
- out = 0, out_valid = 0, err = 0, leds = 0, in_ready = 1.
- FSM = IDLE; blink counter and multiplier state = 0.
REQ-035 Reset asserted during MUL aborts the multiply; no out_valid is produced after release.

Structure
REQ-036 A shared package alsu_pkg holds:
- Opcode constants OP_AND, OP_XOR, OP_ADD, OP_MUL, OP_SHIFT, OP_ROT.
- The FSM state enumeration.
REQ-037 The multiplier is sub-module alsu_seq_mult: start/done, WIDTH-parameterised, 2*WIDTH-bit product, same clk/rst_n.

Verification (WIDTH=4)
REQ-038 Multiply: accept A=13, B=11, opcode 3.
- in_ready = 0 for 4 cycles.
- out = 8'h8F with out_valid 5 cycles after acceptance.
REQ-039 Add: A=15, B=15, cin=1, opcode 2.
- FULL_ADDER="ON": out = 8'h1F next cycle.
- FULL_ADDER="OFF": out = 8'h1E next cycle.
REQ-040 Invalid: opcode 6.
- out = 0, err = 1; leds = 16'hFFFF BLINK_DIV cycles later, then 0 after another BLINK_DIV cycles.
- A following opcode 0 clears err and leds.
REQ-041 Shift and rotate, starting from out = 8'h81:
- opcode 4, direction=1, serial_in=0: out = 8'h02.
- opcode 5, direction=0, from 8'h81: out = 8'hC0.
REQ-042 Bypass and reset:
- bypass_A = bypass_B = 1 with INPUT_PRIORITY="B", A=3, B=9: out = 8'h09.
- rst_n pulsed low mid-multiply: all outputs 0 and in_ready = 1; no out_valid follows.
